mb8_master: RTL and testbench
=============================

Name: mb8_master

Overview:
- Bus initiator for the byte-wide memory port. It drives the 8-bit byte-memory slave, which has one-cycle registered read latency.
- It turns a single 8/16/32-bit word request from the core side into a sequence of byte accesses, then returns an assembled word with a one-cycle ack.
- It sits between the eForth core / debug loader and the 128K byte memory.

Parameters:
AW, 17, byte address width (memory depth 2^AW bytes)
BE, 0, byte order: 0 = little-endian (byte k at addr+k holds bits 8k+7:8k), 1 = big-endian (byte k holds the k-th most significant byte of the N-byte value)

Ports:
clk  input  1  system clock, all logic on rising edge
rst_n  input  1  asynchronous active-low reset
req  input  1  access request, sampled only in IDLE
we  input  1  1 = write, 0 = read; sampled with req
sz  input  2  access size: 0 = 1 byte, 1 = 2 bytes, 2 or 3 = 4 bytes (N = 1/2/4)
ai  input  AW  start byte address; sampled with req
vi  input  32  write data; low N bytes used; sampled with req
busy  output  1  high while state != IDLE
ack  output  1  one-cycle completion pulse
vo  output  32  read result, zero-extended; holds until next read is accepted
m_ai  output  AW  byte-memory address
m_we  output  1  byte-memory write enable
m_vi  output  8  byte-memory write data
m_vo  input  8  byte-memory read data, valid one cycle after address issue

Behaviour:
- Reset (async, any time, including mid-access): state = IDLE, byte counter k = 0, busy = 0, ack = 0, vo = 0, m_ai = 0, m_we = 0, m_vi = 0. Any partial access is abandoned with no ack.
- Registered outputs: all outputs are registered; m_we is never combinationally derived from req.
- States: IDLE, WR, RD, RLAST.
- IDLE:
  - req = 1 at edge E0 latches we, N, ai, vi and sets k = 0.
  - If we = 1: go to WR. If we = 0: clear vo to 0 and go to RD.
  - ack is cleared on any edge where it is not being set.
- WR (N cycles, E0..EN):
  - Each cycle drives m_we = 1, m_ai = (ai + k) mod 2^AW, m_vi = byte k of vi per BE; k increments each edge.
  - At edge EN: m_we = 0, ack = 1, go to IDLE.
  - Timing: ack is high in cycle EN..EN+1; write latency is N cycles.
- RD (N cycles):
  - Each cycle drives m_we = 0, m_ai = ai + k (wrapping); k increments.
  - Byte j (issued in cycle Ej..Ej+1) appears on m_vo in cycle Ej+1..Ej+2 and is captured into the vo byte lane for j (per BE) at edge Ej+2. Captures overlap with issue.
  - At edge EN: go to RLAST.
- RLAST (1 cycle):
  - m_we = 0 and m_ai holds its last value.
  - At edge EN+1: capture the final byte, set ack = 1, go to IDLE.
  - Timing: read latency is N+1 cycles; vo is valid when ack = 1 and holds afterward.
- Requests:
  - A req arriving while busy = 1 is ignored; there is no queuing. The requester must hold req until it sees ack, or re-issue.
  - A req in the ack cycle (state IDLE) is accepted, giving back-to-back throughput of one access per N (write) or N+1 (read) cycles plus one.
- Addressing:
  - Address increments wrap modulo 2^AW; there is no alignment requirement.
  - sz = 3 behaves identically to sz = 2.
- Idle outputs: m_vi and m_ai hold their last values in IDLE, and m_we = 0.

Test Plan:
- Reset then idle: rst_n low mid-sim with req = 0 -> busy = 0, ack = 0, vo = 0, m_we = 0, m_ai = 0 immediately and held.
- 32-bit LE write: req, we = 1, sz = 2, ai = 0x00100, vi = 0xDEADBEEF, BE = 0 -> m_we high 4 cycles, (m_ai, m_vi) = (0x100, EF), (0x101, BE), (0x102, AD), (0x103, DE); ack pulse 4 cycles after accept.
- 32-bit LE read: after the write above, read sz = 2 at 0x00100 -> ack 5 cycles after accept, vo = 0xDEADBEEF; repeat with BE = 1 -> vo = 0xEFBEADDE.
- 8/16-bit zero-extend: with vo previously 0xDEADBEEF, read sz = 0 at 0x00102 -> vo = 0x000000AD after 2 cycles; read sz = 1 at 0x00101 -> vo = 0x0000ADBE after 3 cycles.
- Wrap-around: 16-bit write vi = 0x1234 at 0x1FFFF -> m_ai sequence 0x1FFFF, 0x00000; readback sz = 1 -> 0x1234.
- Busy/reset abort: second req during a 4-byte read is ignored (exactly one ack). Asserting rst_n = 0 in the 2nd RD cycle -> no ack, m_we = 0, next access completes normally.

Source files
------------

// File: rtl/mb8_master.sv
// Byte-wide memory initiator: splits one 8/16/32-bit request into byte accesses
// on a one-cycle-latency byte memory and returns the assembled word with an ack.
module mb8_master #(
    parameter int AW = 17,
    parameter int BE = 0
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          req,
    input  logic          we,
    input  logic [1:0]    sz,
    input  logic [AW-1:0] ai,
    input  logic [31:0]   vi,
    output logic          busy,
    output logic          ack,
    output logic [31:0]   vo,
    output logic [AW-1:0] m_ai,
    output logic          m_we,
    output logic [7:0]    m_vi,
    input  logic [7:0]    m_vo
);

    typedef enum logic [1:0] {IDLE, WR, RD, RLAST} state_t;

    state_t        state, state_nx;
    logic [2:0]    k, k_nx;
    logic [1:0]    kl, kl_nx;
    logic [AW-1:0] a_r, a_nx;
    logic [31:0]   v_r, v_nx;
    logic          busy_nx, ack_nx, m_we_nx;
    logic [31:0]   vo_nx;
    logic [AW-1:0] m_ai_nx;
    logic [7:0]    m_vi_nx;
    logic [1:0]    kl_req;
    logic [2:0]    n;

    // Word lane holding byte idx of an access whose last byte index is last.
    function automatic logic [1:0] lane(input logic [1:0] idx, input logic [1:0] last);
        if (BE != 0)
            return last - idx;
        else
            return idx;
    endfunction

    always_comb begin
        unique case (sz)
            2'd0:    kl_req = 2'd0;
            2'd1:    kl_req = 2'd1;
            default: kl_req = 2'd3;
        endcase
    end

    assign n = {1'b0, kl} + 3'd1;

    always_comb begin
        state_nx = state;
        k_nx     = k;
        kl_nx    = kl;
        a_nx     = a_r;
        v_nx     = v_r;
        ack_nx   = 1'b0;
        m_we_nx  = 1'b0;
        vo_nx    = vo;
        m_ai_nx  = m_ai;
        m_vi_nx  = m_vi;

        unique case (state)
            IDLE: begin
                if (req) begin
                    kl_nx   = kl_req;
                    a_nx    = ai;
                    v_nx    = vi;
                    m_ai_nx = ai;
                    // Byte 0 is issued on the accepting edge, so the counter starts at 1.
                    k_nx    = 3'd1;
                    if (we) begin
                        state_nx = WR;
                        m_we_nx  = 1'b1;
                        m_vi_nx  = vi[{lane(2'd0, kl_req), 3'b000} +: 8];
                    end else begin
                        state_nx = RD;
                        vo_nx    = '0;
                    end
                end
            end
            WR: begin
                if (k == n) begin
                    state_nx = IDLE;
                    ack_nx   = 1'b1;
                    k_nx     = '0;
                end else begin
                    m_we_nx = 1'b1;
                    m_ai_nx = a_r + AW'(k);
                    m_vi_nx = v_r[{lane(k[1:0], kl), 3'b000} +: 8];
                    k_nx    = k + 3'd1;
                end
            end
            RD: begin
                // Data for byte k-2 arrives now; capture overlaps with issuing byte k.
                if (k >= 3'd2)
                    vo_nx[{lane(2'(k - 3'd2), kl), 3'b000} +: 8] = m_vo;
                if (k == n) begin
                    state_nx = RLAST;
                end else begin
                    m_ai_nx = a_r + AW'(k);
                    k_nx    = k + 3'd1;
                end
            end
            RLAST: begin
                vo_nx[{lane(kl, kl), 3'b000} +: 8] = m_vo;
                ack_nx   = 1'b1;
                state_nx = IDLE;
                k_nx     = '0;
            end
            default: state_nx = IDLE;
        endcase

        busy_nx = (state_nx != IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            k     <= '0;
            kl    <= '0;
            a_r   <= '0;
            v_r   <= '0;
            busy  <= 1'b0;
            ack   <= 1'b0;
            vo    <= '0;
            m_ai  <= '0;
            m_we  <= 1'b0;
            m_vi  <= '0;
        end else begin
            state <= state_nx;
            k     <= k_nx;
            kl    <= kl_nx;
            a_r   <= a_nx;
            v_r   <= v_nx;
            busy  <= busy_nx;
            ack   <= ack_nx;
            vo    <= vo_nx;
            m_ai  <= m_ai_nx;
            m_we  <= m_we_nx;
            m_vi  <= m_vi_nx;
        end
    end

endmodule

// File: tb/tb_mb8_master.sv
// Directed bench for mb8_master: little- and big-endian instances share one
// byte memory model with one-cycle registered read latency.
module tb_mb8_master;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_a = 1'b0, req_b = 1'b0;
    logic        we = 1'b0;
    logic [1:0]  sz = 2'd0;
    logic [16:0] ai = '0;
    logic [31:0] vi = '0;
    logic        sel = 1'b0;
    logic [7:0]  m_vo;

    logic        busy_a, ack_a, m_we_a, busy_b, ack_b, m_we_b;
    logic [31:0] vo_a, vo_b;
    logic [16:0] m_ai_a, m_ai_b;
    logic [7:0]  m_vi_a, m_vi_b;

    logic [7:0]  mem [0:(1<<17)-1];

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    mb8_master #(.AW(17), .BE(0)) u_le (
        .clk(clk), .rst_n(rst_n), .req(req_a), .we(we), .sz(sz), .ai(ai), .vi(vi),
        .busy(busy_a), .ack(ack_a), .vo(vo_a),
        .m_ai(m_ai_a), .m_we(m_we_a), .m_vi(m_vi_a), .m_vo(m_vo)
    );

    mb8_master #(.AW(17), .BE(1)) u_be (
        .clk(clk), .rst_n(rst_n), .req(req_b), .we(we), .sz(sz), .ai(ai), .vi(vi),
        .busy(busy_b), .ack(ack_b), .vo(vo_b),
        .m_ai(m_ai_b), .m_we(m_we_b), .m_vi(m_vi_b), .m_vo(m_vo)
    );

    always @(posedge clk) begin
        if (m_we_a) mem[m_ai_a] <= m_vi_a;
        if (m_we_b) mem[m_ai_b] <= m_vi_b;
        m_vo <= mem[sel ? m_ai_b : m_ai_a];
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_cmp++;
        if (obs !== exp_v) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp_v);
        end
    endtask

    function automatic logic cur_ack();
        return sel ? ack_b : ack_a;
    endfunction

    function automatic logic [31:0] cur_vo();
        return sel ? vo_b : vo_a;
    endfunction

    task automatic start(input logic b, input logic w, input logic [1:0] s,
                         input logic [16:0] a, input logic [31:0] v);
        sel = b; we = w; sz = s; ai = a; vi = v;
        if (b) req_b = 1'b1; else req_a = 1'b1;
        @(posedge clk); #1;
        req_a = 1'b0; req_b = 1'b0;
    endtask

    task automatic wait_ack(output int lat);
        lat = 0;
        for (int i = 1; i <= 20; i++) begin
            @(posedge clk); #1;
            if (cur_ack()) begin
                lat = i;
                break;
            end
        end
    endtask

    task automatic access(input string tag, input logic b, input logic w, input logic [1:0] s,
                          input logic [16:0] a, input logic [31:0] v,
                          input int exp_lat, input logic [31:0] exp_vo);
        int lat;
        start(b, w, s, a, v);
        wait_ack(lat);
        chk({tag, "_lat"}, lat, exp_lat);
        if (!w) chk({tag, "_vo"}, cur_vo(), exp_vo);
    endtask

    initial begin
        logic [16:0] wa [4];
        logic [7:0]  wd [4];
        int lat, acks, wrs;
        wa = '{17'h00100, 17'h00101, 17'h00102, 17'h00103};
        wd = '{8'hEF, 8'hBE, 8'hAD, 8'hDE};

        repeat (2) @(posedge clk);
        #1;
        chk("rst_busy", busy_a, 0);
        chk("rst_ack", ack_a, 0);
        chk("rst_vo", vo_a, 0);
        chk("rst_mwe", m_we_a, 0);
        chk("rst_mai", m_ai_a, 0);
        chk("rst_mvi", m_vi_a, 0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // 32-bit little-endian write, byte-by-byte bus check
        start(1'b0, 1'b1, 2'd2, 17'h00100, 32'hDEADBEEF);
        for (int j = 0; j < 4; j++) begin
            if (j > 0) begin @(posedge clk); #1; end
            chk($sformatf("wr_mwe%0d", j), m_we_a, 1);
            chk($sformatf("wr_mai%0d", j), m_ai_a, wa[j]);
            chk($sformatf("wr_mvi%0d", j), m_vi_a, wd[j]);
            chk($sformatf("wr_ack%0d", j), ack_a, 0);
            chk($sformatf("wr_busy%0d", j), busy_a, 1);
        end
        @(posedge clk); #1;
        chk("wr_end_mwe", m_we_a, 0);
        chk("wr_end_ack", ack_a, 1);
        chk("wr_end_busy", busy_a, 0);
        @(posedge clk); #1;
        chk("wr_ack_drop", ack_a, 0);
        chk("wr_mai_hold", m_ai_a, 17'h00103);

        // mid-sim reset while idle
        rst_n = 1'b0;
        #1;
        chk("rst2_busy", busy_a, 0);
        chk("rst2_ack", ack_a, 0);
        chk("rst2_vo", vo_a, 0);
        chk("rst2_mwe", m_we_a, 0);
        chk("rst2_mai", m_ai_a, 0);
        @(posedge clk); #1;
        chk("rst2_mai_held", m_ai_a, 0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        access("rd32", 1'b0, 1'b0, 2'd2, 17'h00100, '0, 5, 32'hDEADBEEF);

        start(1'b0, 1'b0, 2'd0, 17'h00102, '0);
        chk("rd8_clr", vo_a, 0);
        wait_ack(lat);
        chk("rd8_lat", lat, 2);
        chk("rd8_vo", vo_a, 32'h000000AD);

        access("rd16", 1'b0, 1'b0, 2'd1, 17'h00101, '0, 3, 32'h0000ADBE);
        access("rd32_sz3", 1'b0, 1'b0, 2'd3, 17'h00100, '0, 5, 32'hDEADBEEF);
        @(posedge clk); #1;
        chk("vo_hold", vo_a, 32'hDEADBEEF);

        // big-endian instance
        access("be_rd32", 1'b1, 1'b0, 2'd2, 17'h00100, '0, 5, 32'hEFBEADDE);
        start(1'b1, 1'b1, 2'd2, 17'h00200, 32'h11223344);
        chk("be_wr_mai0", m_ai_b, 17'h00200);
        chk("be_wr_mvi0", m_vi_b, 8'h11);
        wait_ack(lat);
        chk("be_wr_lat", lat, 4);
        access("le_rd_be", 1'b0, 1'b0, 2'd2, 17'h00200, '0, 5, 32'h44332211);
        access("be_rd_be", 1'b1, 1'b0, 2'd2, 17'h00200, '0, 5, 32'h11223344);
        access("be_rd16", 1'b1, 1'b0, 2'd1, 17'h00201, '0, 3, 32'h00002233);

        // address wrap
        start(1'b0, 1'b1, 2'd1, 17'h1FFFF, 32'h00001234);
        chk("wrap_mai0", m_ai_a, 17'h1FFFF);
        chk("wrap_mvi0", m_vi_a, 8'h34);
        @(posedge clk); #1;
        chk("wrap_mai1", m_ai_a, 17'h00000);
        chk("wrap_mvi1", m_vi_a, 8'h12);
        @(posedge clk); #1;
        chk("wrap_ack", ack_a, 1);
        access("wrap_rd", 1'b0, 1'b0, 2'd1, 17'h1FFFF, '0, 3, 32'h00001234);

        // request while busy is ignored
        start(1'b0, 1'b0, 2'd2, 17'h00100, '0);
        we = 1'b1; ai = 17'h00200; vi = 32'hCAFEF00D; req_a = 1'b1;
        acks = 0; wrs = 0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            if (i == 2) req_a = 1'b0;
            if (ack_a) acks++;
            if (m_we_a) wrs++;
        end
        chk("busy_acks", acks, 1);
        chk("busy_writes", wrs, 0);
        chk("busy_vo", vo_a, 32'hDEADBEEF);

        // reset abort in the second read cycle
        start(1'b0, 1'b0, 2'd2, 17'h00100, '0);
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        chk("abort_busy", busy_a, 0);
        chk("abort_mwe", m_we_a, 0);
        chk("abort_mai", m_ai_a, 0);
        chk("abort_vo", vo_a, 0);
        acks = 0;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            if (i == 2) rst_n = 1'b1;
            if (ack_a) acks++;
        end
        chk("abort_acks", acks, 0);
        access("after_abort", 1'b0, 1'b0, 2'd2, 17'h00100, '0, 5, 32'hDEADBEEF);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
